radix_digit_seq: RTL and testbench
==================================

Name: radix_digit_seq

Overview:
Sequencer that takes a WIDTH-bit unsigned value and a radix code, and streams its digits out one per handshake in binary, octal, decimal or hex.
- Power-of-two radices use a shift datapath.
- Decimal uses a bit-serial divide-by-10 datapath.
- Sits between constant/register sources and text/debug output logic on the sysclk domain.

Parameters:
WIDTH, 32, width of input value (min 4)
MAXDIG, 32, digit-buffer depth; must be >= WIDTH (the binary worst case)

Ports:
sysclk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request: value and radix are valid
in_ready  output  1  sequencer can accept a request
in_value  input  WIDTH  unsigned value to convert
in_radix  input  2  radix: 00=2, 01=8, 10=10, 11=16
dig_valid  output  1  digit output valid
dig_ready  input  1  consumer accepts digit
dig_value  output  4  digit, 0..radix-1
dig_last  output  1  marks final digit of the value
busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Clocking and reset: one clock, sysclk. Reset is asynchronous, active-low, on port rst_n.
- Reset values: state=IDLE; in_ready=1; dig_valid=0; dig_value=0; dig_last=0; busy=0; all internal registers cleared.
- Accept: a request is accepted on a cycle with in_valid && in_ready. in_ready=1 only in IDLE, so requests never overlap. in_value and in_radix are latched on accept.
- FSM states: IDLE, SHIFT, DIV, EMIT.
  - IDLE -> SHIFT when radix is 2/8/16.
  - IDLE -> DIV when radix is 10.
  - SHIFT/DIV -> EMIT when a digit is ready.
  - EMIT -> IDLE on dig_valid && dig_ready && dig_last.
  - EMIT -> SHIFT/DIV on dig_valid && dig_ready && !dig_last.
- SHIFT (1 cycle):
  - digit = low log2(radix) bits of the working value.
  - Working value is shifted right by 1/3/4 with zero fill. Octal with WIDTH not a multiple of 3 takes zero-filled top bits.
  - dig_last = (shifted remainder == 0).
- DIV (WIDTH cycles):
  - Restoring bit-serial divide of the working value by 10, one quotient bit per cycle, MSB first.
  - At completion: digit = remainder (0..9), working value = quotient, dig_last = (quotient == 0).
- Digit order: digits are emitted LSB first. Leading zeros are suppressed. An input of 0 emits exactly one digit, 0, with dig_last=1.
- Output handshake: dig_valid is asserted in EMIT. dig_value and dig_last hold stable until dig_ready. Dropping dig_ready is legal at any cycle and stalls the FSM with no loss.
- Latency, accept to first dig_valid:
  - Power-of-two radix: 2 cycles.
  - Decimal: WIDTH+2 cycles.
- Throughput with dig_ready held high:
  - Power-of-two radix: one digit per 2 cycles.
  - Decimal: one digit per WIDTH+1 cycles.
- Back-to-back: in_ready returns the cycle after the last digit's handshake. It is not combinationally tied to dig_ready.
- Reset mid-operation: async abort to the reset values. A partially emitted digit stream is discarded and no dig_last is produced.
- Width rules:
  - Working register is WIDTH bits; remainder register is 4 bits.
  - The divider compares {remainder, next bit} (5 bits) against 10 and subtracts when it is >= 10.

Optional Feature:
RADIX_MSB_FIRST_EN
- Defined:
  - Digits are generated as above but pushed into a MAXDIG x 4 LIFO during generation. No handshake occurs in this phase.
  - Once the final digit is generated, the FSM enters EMIT and pops the digits MSB first; dig_last marks the least-significant digit.
  - Adds a DRAIN-style EMIT using the LIFO pointer; first-digit latency becomes the full conversion time plus 1 cycle.
  - LIFO full cannot occur because MAXDIG >= WIDTH.
- Undefined: no LIFO is instantiated; LSB-first streaming as specified.

Decomposition:
- Package radix_pkg:
  - radix codes RADIX_BIN/OCT/DEC/HEX;
  - FSM state enum;
  - DIGIT_W=4;
  - shift-per-radix constant function.
- Sub-module radix_div10_serial:
  - start/done interface; WIDTH-cycle restoring divider;
  - outputs quotient and 4-bit remainder.
- Top-level keeps the FSM, the shift path, the handshakes and the optional LIFO.

Test Plan:
1. Decimal 123, dig_ready=1 -> digits 3,2,1; dig_last on 1; first dig_valid at cycle WIDTH+2 after accept.
2. Hex 0x12AF -> F,A,2,1 with last on 1. Octal 0177362 -> 2,6,3,7,7,1.
3. Binary 0b00101101110111 -> 1,1,1,0,1,1,1,0,1,1,0,1 (12 digits, no leading zeros). Value 0 in any radix -> single digit 0 with last=1.
4. Backpressure: decimal 1234 with dig_ready low 5 cycles at each digit -> dig_value/dig_last stable while stalled; sequence 4,3,2,1 intact; in_ready stays 0 until the last handshake.
5. rst_n pulsed low during DIV of decimal 0xFFFFFFFF -> all outputs at reset values immediately; a following hex 0x10 request yields 0,1 correctly.
6. With RADIX_MSB_FIRST_EN: decimal 1234 -> 1,2,3,4 with last on 4; hex 0xFFFFFFFF -> 8 F digits, last on the 8th.

Source files
------------

// File: rtl/radix_pkg.sv
// Shared types and helpers for the radix digit sequencer.
// Radix codes, FSM state encoding, digit width and per-radix shift/mask helpers.
package radix_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      RADIX_BIN = 2'b00,
      RADIX_OCT = 2'b01,
      RADIX_DEC = 2'b10,
      RADIX_HEX = 2'b11
   } radix_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DIV   = 2'd2,
      ST_EMIT  = 2'd3
   } state_e;

   // Bits consumed per digit on the shift path; decimal never takes this path.
   function automatic logic [2:0] radix_shift(input radix_e radix);
      case (radix)
         RADIX_BIN: radix_shift = 3'd1;
         RADIX_OCT: radix_shift = 3'd3;
         RADIX_HEX: radix_shift = 3'd4;
         default:   radix_shift = 3'd0;
      endcase
   endfunction

   // Mask selecting the low log2(radix) bits of the working value.
   function automatic logic [DIGIT_W-1:0] radix_mask(input radix_e radix);
      case (radix)
         RADIX_BIN: radix_mask = 4'h1;
         RADIX_OCT: radix_mask = 4'h7;
         RADIX_HEX: radix_mask = 4'hF;
         default:   radix_mask = 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/radix_div10_serial.sv
// Bit-serial restoring divide-by-10.
// A start pulse loads the dividend and performs the first quotient step in the
// same cycle; the remaining WIDTH-1 steps follow one per cycle, MSB first.
// o_done pulses for one cycle once quotient and remainder are final; both are
// held until the next start.
module radix_div10_serial
   import radix_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               sysclk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_dividend,
   output logic               o_done,
   output logic [WIDTH-1:0]   o_quot,
   output logic [DIGIT_W-1:0] o_rem
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   r_dvd;
   logic [DIGIT_W-1:0] r_rem;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;

   logic [WIDTH-1:0]   w_src_dvd;
   logic [DIGIT_W-1:0] w_src_rem;
   logic [DIGIT_W:0]   w_trial;
   logic               w_ge;
   logic [DIGIT_W-1:0] w_rem_nx;
   logic [WIDTH-1:0]   w_dvd_nx;

   // One restoring step: bring in the next dividend bit, subtract 10 if it fits.
   always_comb begin
      // NOTE: every always_comb output is given a default first so no path can
      // leave it unassigned and infer a latch.
      w_src_dvd = r_dvd;
      w_src_rem = r_rem;
      if (i_start) begin
         w_src_dvd = i_dividend;
         w_src_rem = '0;
      end
      w_trial  = {w_src_rem, w_src_dvd[WIDTH-1]};
      w_ge     = (w_trial >= 5'd10);
      w_rem_nx = w_ge ? DIGIT_W'(w_trial - 5'd10) : w_trial[DIGIT_W-1:0];
      w_dvd_nx = {w_src_dvd[WIDTH-2:0], w_ge};
   end

   // Shift register holds dividend bits on the left and quotient bits on the right.
   always_ff @(posedge sysclk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_dvd  <= '0;
         r_rem  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (i_start) begin
         r_dvd  <= w_dvd_nx;
         r_rem  <= w_rem_nx;
         r_cnt  <= CNT_W'(1);
         r_busy <= 1'b1;
         r_done <= 1'b0;
      end else if (r_busy) begin
         r_dvd <= w_dvd_nx;
         r_rem <= w_rem_nx;
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end else begin
         r_done <= 1'b0;
      end
   end

   assign o_done = r_done;
   assign o_quot = r_dvd;
   assign o_rem  = r_rem;

endmodule

// File: rtl/radix_digit_seq.sv
// Radix digit sequencer: converts an unsigned WIDTH-bit value into a stream of
// base-2/8/10/16 digits, one per dig_valid/dig_ready handshake.
// Power-of-two radices peel digits off with a shift; decimal uses the
// bit-serial divide-by-10 sub-module.
// Build option RADIX_MSB_FIRST_EN: digits are collected in a MAXDIG-deep LIFO
// during conversion and then streamed most-significant first.
// Requires WIDTH >= 4 and MAXDIG >= WIDTH.
module radix_digit_seq
   import radix_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MAXDIG = 32
) (
   input  logic               sysclk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_value,
   input  logic [1:0]         in_radix,
   output logic               dig_valid,
   input  logic               dig_ready,
   output logic [DIGIT_W-1:0] dig_value,
   output logic               dig_last,
   output logic               busy
);

   if (WIDTH < 4 || MAXDIG < WIDTH) begin : g_param_check
      $error("radix_digit_seq: WIDTH must be >= 4 and MAXDIG >= WIDTH");
   end

   state_e             r_state;
   state_e             w_state_nx;
   logic [WIDTH-1:0]   r_work;
   radix_e             r_radix;
   logic               r_kick;

   logic               w_accept;
   logic               w_hs;
   logic               w_emit_last;
   logic [WIDTH-1:0]   w_shifted;
   logic [DIGIT_W-1:0] w_shift_dig;

   logic               w_div_start;
   logic               w_div_done;
   logic [WIDTH-1:0]   w_dividend;
   logic [WIDTH-1:0]   w_quot;
   logic [DIGIT_W-1:0] w_rem;

   // Shift path: current digit and the remaining value after removing it.
   always_comb begin
      w_shift_dig = r_work[DIGIT_W-1:0] & radix_mask(r_radix);
      w_shifted   = r_work >> radix_shift(r_radix);
   end

   // State register.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nx;
   end

   // Next-state logic and state-decoded handshake outputs.
   always_comb begin
      w_state_nx = r_state;
      in_ready   = 1'b0;
      dig_valid  = 1'b0;
      busy       = 1'b1;
      w_accept   = 1'b0;
      w_hs       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_accept   = 1'b1;
               w_state_nx = (radix_e'(in_radix) == RADIX_DEC) ? ST_DIV : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
`ifdef RADIX_MSB_FIRST_EN
            if (w_shifted == '0) w_state_nx = ST_EMIT;
`else
            w_state_nx = ST_EMIT;
`endif
         end
         ST_DIV: begin
            if (w_div_done) begin
`ifdef RADIX_MSB_FIRST_EN
               if (w_quot == '0) w_state_nx = ST_EMIT;
`else
               w_state_nx = ST_EMIT;
`endif
            end
         end
         ST_EMIT: begin
            dig_valid = 1'b1;
            if (dig_ready) begin
               w_hs = 1'b1;
               if (w_emit_last) begin
                  w_state_nx = ST_IDLE;
               end else begin
`ifndef RADIX_MSB_FIRST_EN
                  w_state_nx = (r_radix == RADIX_DEC) ? ST_DIV : ST_SHIFT;
`endif
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // The first division of a request is kicked one cycle after accept, from the
   // latched value; later divisions restart straight from the held quotient.
   assign w_dividend = r_kick ? r_work : w_quot;

`ifdef RADIX_MSB_FIRST_EN
   assign w_div_start = r_kick || (r_state == ST_DIV && w_div_done && w_quot != '0);
`else
   assign w_div_start = r_kick || (w_hs && !w_emit_last && r_radix == RADIX_DEC);
`endif

   radix_div10_serial #(
      .WIDTH (WIDTH)
   ) u_div10 (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .i_start    (w_div_start),
      .i_dividend (w_dividend),
      .o_done     (w_div_done),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   // Working value and radix: loaded on accept, reduced by each generated digit.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_work  <= '0;
         r_radix <= RADIX_BIN;
         r_kick  <= 1'b0;
      end else begin
         r_kick <= w_accept && (radix_e'(in_radix) == RADIX_DEC);
         if (w_accept) begin
            r_work  <= in_value;
            r_radix <= radix_e'(in_radix);
         end else if (r_state == ST_SHIFT) begin
            r_work <= w_shifted;
         end else if (r_state == ST_DIV && w_div_done) begin
            r_work <= w_quot;
         end
      end
   end

`ifdef RADIX_MSB_FIRST_EN
   localparam int PTR_W = $clog2(MAXDIG + 1);
   localparam int IDX_W = $clog2(MAXDIG);

   logic [DIGIT_W-1:0] r_lifo [MAXDIG];
   logic [PTR_W-1:0]   r_ptr;
   logic               w_push;
   logic [DIGIT_W-1:0] w_push_dig;
   logic [IDX_W-1:0]   w_top;

   // Every generated digit is pushed; none is offered to the consumer yet.
   always_comb begin
      w_push     = (r_state == ST_SHIFT) || (r_state == ST_DIV && w_div_done);
      w_push_dig = (r_state == ST_SHIFT) ? w_shift_dig : w_rem;
      w_top      = IDX_W'(r_ptr - PTR_W'(1));
   end

   // LIFO occupancy: grows during conversion, shrinks by one per handshake.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n)      r_ptr <= '0;
      else if (w_push) r_ptr <= r_ptr + PTR_W'(1);
      else if (w_hs)   r_ptr <= r_ptr - PTR_W'(1);
   end

   // LIFO storage.
   always_ff @(posedge sysclk) begin
      // NOTE: the storage array has no reset; only the pointer is cleared, and
      // entries above the pointer are never read.
      if (w_push) r_lifo[IDX_W'(r_ptr)] <= w_push_dig;
   end

   assign w_emit_last = (r_ptr == PTR_W'(1));
   assign dig_value   = dig_valid ? r_lifo[w_top] : '0;
   assign dig_last    = dig_valid && w_emit_last;
`else
   logic [DIGIT_W-1:0] r_dig;
   logic               r_last;

   // Output digit register: captured when a digit is generated, held through stalls.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_dig  <= '0;
         r_last <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
         r_dig  <= w_shift_dig;
         r_last <= (w_shifted == '0);
      end else if (r_state == ST_DIV && w_div_done) begin
         r_dig  <= w_rem;
         r_last <= (w_quot == '0);
      end
   end

   assign w_emit_last = r_last;
   assign dig_value   = r_dig;
   assign dig_last    = r_last;
`endif

endmodule

// File: tb/tb_radix_digit_seq.sv
// Directed bench for radix_digit_seq: a table of requests with hand-computed
// digit strings, plus a mid-conversion reset sequence. Expected digits are
// stored as nibbles, least-significant digit in nibble 0.
module tb_radix_digit_seq;

   localparam int WIDTH  = 32;
   localparam int MAXDIG = 32;

   localparam logic [1:0] R_BIN = 2'b00;
   localparam logic [1:0] R_OCT = 2'b01;
   localparam logic [1:0] R_DEC = 2'b10;
   localparam logic [1:0] R_HEX = 2'b11;

   logic             sysclk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_value;
   logic [1:0]       in_radix;
   logic             dig_valid;
   logic             dig_ready;
   logic [3:0]       dig_value;
   logic             dig_last;
   logic             busy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0]   radix;
      logic [31:0]  value;
      logic [127:0] digs;
      int           ndig;
      int           stall;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   radix_digit_seq #(
      .WIDTH  (WIDTH),
      .MAXDIG (MAXDIG)
   ) dut (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .in_radix  (in_radix),
      .dig_valid (dig_valid),
      .dig_ready (dig_ready),
      .dig_value (dig_value),
      .dig_last  (dig_last),
      .busy      (busy)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic set_vec(input int i, input logic [1:0] r, input logic [31:0] v,
                          input logic [127:0] d, input int n, input int s);
      vecs[i].radix = r;
      vecs[i].value = v;
      vecs[i].digs  = d;
      vecs[i].ndig  = n;
      vecs[i].stall = s;
   endtask

   // Issue one request and collect/check its whole digit stream.
   task automatic run_vec(input int i);
      vec_t         v;
      logic [127:0] d;
      int           cyc;
      int           t_prev;
      int           guard;
      int           kexp;
      logic [3:0]   exp_dig;
      logic         exp_last;
      v = vecs[i];
      d = v.digs;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge sysclk);
         guard++;
      end
      if (!in_ready) begin
         fail_timeout($sformatf("v%0d in_ready", i));
         return;
      end
      in_valid  = 1'b1;
      in_value  = v.value;
      in_radix  = v.radix;
      dig_ready = (v.stall == 0);
      cyc    = 0;
      t_prev = 0;
      @(negedge sysclk);
      cyc++;
      in_valid = 1'b0;
      check($sformatf("v%0d busy_after_accept", i), {30'd0, busy, in_ready}, 32'b10);
      for (int k = 0; k < v.ndig; k++) begin
         guard = 0;
         while (!dig_valid && guard < 2 * WIDTH + 8) begin
            @(negedge sysclk);
            cyc++;
            guard++;
         end
         if (!dig_valid) begin
            fail_timeout($sformatf("v%0d digit%0d dig_valid", i, k));
            dig_ready = 1'b0;
            return;
         end
`ifndef RADIX_MSB_FIRST_EN
         if (v.stall == 0) begin
            if (k == 0)
               check($sformatf("v%0d latency", i), cyc, (v.radix == R_DEC) ? WIDTH + 2 : 2);
            else
               check($sformatf("v%0d gap%0d", i, k), cyc - t_prev, (v.radix == R_DEC) ? WIDTH + 1 : 2);
         end
`endif
         t_prev = cyc;
`ifdef RADIX_MSB_FIRST_EN
         kexp = v.ndig - 1 - k;
`else
         kexp = k;
`endif
         exp_dig  = d[4*kexp +: 4];
         exp_last = (k == v.ndig - 1);
         check($sformatf("v%0d digit%0d value", i, k), dig_value, exp_dig);
         check($sformatf("v%0d digit%0d last", i, k), dig_last, exp_last);
         if (v.stall > 0) begin
            for (int s = 0; s < v.stall; s++) begin
               @(negedge sysclk);
               cyc++;
               check($sformatf("v%0d digit%0d stall%0d value", i, k, s), dig_value, exp_dig);
               check($sformatf("v%0d digit%0d stall%0d flags", i, k, s),
                     {29'd0, dig_valid, dig_last, in_ready}, {29'd0, 1'b1, exp_last, 1'b0});
            end
            dig_ready = 1'b1;
         end
         @(negedge sysclk);
         cyc++;
         if (v.stall > 0) dig_ready = 1'b0;
      end
      check($sformatf("v%0d end_flags", i), {29'd0, in_ready, dig_valid, busy}, 32'b100);
      dig_ready = 1'b0;
   endtask

   initial begin
      // radix, value, digit nibbles (LSD in nibble 0), digit count, stall cycles
      set_vec(0,  R_DEC, 32'd123,          128'h123, 3, 0);
      set_vec(1,  R_HEX, 32'h12AF,         128'h12AF, 4, 0);
      set_vec(2,  R_OCT, 32'o177362,       128'h177362, 6, 0);
      set_vec(3,  R_BIN, 32'b00101101110111, 128'h101101110111, 12, 0);
      set_vec(4,  R_BIN, 32'd0,            128'h0, 1, 0);
      set_vec(5,  R_OCT, 32'd0,            128'h0, 1, 0);
      set_vec(6,  R_DEC, 32'd0,            128'h0, 1, 0);
      set_vec(7,  R_HEX, 32'd0,            128'h0, 1, 0);
      set_vec(8,  R_DEC, 32'd1234,         128'h1234, 4, 5);
      set_vec(9,  R_DEC, 32'hFFFF_FFFF,    128'h4294967295, 10, 0);
      set_vec(10, R_HEX, 32'hFFFF_FFFF,    128'hFFFFFFFF, 8, 0);
      set_vec(11, R_BIN, 32'h8000_0000,    128'h1000_0000_0000_0000_0000_0000_0000_0000, 32, 0);
      set_vec(12, R_OCT, 32'hFFFF_FFFF,    128'h37777777777, 11, 0);
      set_vec(13, R_DEC, 32'd9,            128'h9, 1, 0);
      set_vec(14, R_DEC, 32'd10,           128'h10, 2, 0);
      set_vec(15, R_HEX, 32'hA5,           128'hA5, 2, 3);
      set_vec(16, R_HEX, 32'h10,           128'h10, 2, 0);

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_value  = '0;
      in_radix  = 2'b00;
      dig_ready = 1'b0;
      #1;
      check("reset outputs", {27'd0, in_ready, dig_valid, dig_value, dig_last, busy},
            {27'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
      repeat (3) @(negedge sysclk);
      rst_n = 1'b1;
      @(negedge sysclk);
      check("idle after reset", {30'd0, in_ready, busy}, 32'b10);

      for (int i = 0; i < NVEC - 1; i++) run_vec(i);

      // Abort a long decimal conversion part way through the divide.
      @(negedge sysclk);
      in_valid = 1'b1;
      in_value = 32'hFFFF_FFFF;
      in_radix = R_DEC;
      @(negedge sysclk);
      in_valid = 1'b0;
      repeat (10) @(negedge sysclk);
      check("mid-div busy", {30'd0, busy, dig_valid}, 32'b10);
      rst_n = 1'b0;
      #1;
      check("async abort outputs", {27'd0, in_ready, dig_valid, dig_value, dig_last, busy},
            {27'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0});
      @(negedge sysclk);
      check("held in reset", {29'd0, in_ready, dig_valid, busy}, 32'b100);
      rst_n = 1'b1;
      @(negedge sysclk);
      run_vec(NVEC - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
